// File: rtl/cpu_pkg.sv
// Shared pipeline encodings: writeback source selects, load/store kinds and
// the hardwired-zero register index.
package cpu_pkg;

   localparam logic [2:0] W2R_ALU = 3'd0;
   localparam logic [2:0] W2R_MEM = 3'd1;
   localparam logic [2:0] W2R_PC8 = 3'd2;
   localparam logic [2:0] W2R_CP0 = 3'd3;

   localparam logic [3:0] LS_LW  = 4'd0;
   localparam logic [3:0] LS_LH  = 4'd1;
   localparam logic [3:0] LS_LHU = 4'd2;
   localparam logic [3:0] LS_LB  = 4'd3;
   localparam logic [3:0] LS_LBU = 4'd4;

   localparam logic [4:0] REG_ZERO = 5'd0;

   localparam logic [31:0] PC_LINK_OFFSET = 32'd8;

endpackage

// File: rtl/load_ext.sv
// Load extension: picks the addressed byte/halfword out of the raw memory word
// and sign- or zero-extends it according to the load kind.
module load_ext
   import cpu_pkg::*;
(
   input  logic [3:0]  lsOp,
   input  logic [1:0]  off,
   input  logic [31:0] word,
   output logic [31:0] ext
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word[7:0];
      case (off)
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase
      half_sel = off[1] ? word[31:16] : word[15:0];
   end

   // Unknown kinds fall back to the raw word so stores or new opcodes are harmless.
   always_comb begin
      ext = word;
      case (lsOp)
         LS_LW:   ext = word;
         LS_LH:   ext = {{16{half_sel[15]}}, half_sel};
         LS_LHU:  ext = {16'h0000, half_sel};
         LS_LB:   ext = {{24{byte_sel[7]}}, byte_sel};
         LS_LBU:  ext = {24'h000000, byte_sel};
         default: ext = word;
      endcase
   end

endmodule

// File: rtl/wb_grf.sv
// Writeback stage and general register file with write-to-read bypass.
// Define GRF_TRACE_EN to add the registered commit-trace outputs.
module wb_grf
   import cpu_pkg::*;
#(
   parameter int NREG = 32
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        regWrite_W,
   input  logic [4:0]  A3_W,
   input  logic [2:0]  write2reg_W,
   input  logic [3:0]  lsOp_W,
   input  logic [31:0] readData_W,
   input  logic [31:0] aluResult_W,
   input  logic [31:0] PC_W,
   input  logic [31:0] cp0Out_W,
   input  logic [4:0]  A1_D,
   input  logic [4:0]  A2_D,
   output logic [31:0] RD1_D,
   output logic [31:0] RD2_D,
   output logic [31:0] WD_W
`ifdef GRF_TRACE_EN
  ,output logic        trace_valid,
   output logic [31:0] trace_pc,
   output logic [4:0]  trace_reg,
   output logic [31:0] trace_data
`endif
);

   logic [31:0] regs_q [NREG];
   logic [31:0] load_data;
   logic        we;

   load_ext u_load_ext (
      .lsOp (lsOp_W),
      .off  (aluResult_W[1:0]),
      .word (readData_W),
      .ext  (load_data)
   );

   always_comb begin
      WD_W = '0;
      case (write2reg_W)
         W2R_ALU: WD_W = aluResult_W;
         W2R_MEM: WD_W = load_data;
         W2R_PC8: WD_W = PC_W + PC_LINK_OFFSET;
         W2R_CP0: WD_W = cp0Out_W;
         default: WD_W = '0;
      endcase
   end

   assign we = regWrite_W && (A3_W != REG_ZERO);

   // $0 is never written because we excludes it, so its entry stays at reset value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else if (we) begin
         regs_q[A3_W] <= WD_W;
      end
   end

   // Bypass lets the D stage see the W result in the same cycle it commits.
   assign RD1_D = (A1_D == REG_ZERO)        ? '0   :
                  (we && (A1_D == A3_W))    ? WD_W : regs_q[A1_D];
   assign RD2_D = (A2_D == REG_ZERO)        ? '0   :
                  (we && (A2_D == A3_W))    ? WD_W : regs_q[A2_D];

`ifdef GRF_TRACE_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         trace_valid <= 1'b0;
         trace_pc    <= '0;
         trace_reg   <= '0;
         trace_data  <= '0;
      end else if (we) begin
         trace_valid <= 1'b1;
         trace_pc    <= PC_W;
         trace_reg   <= A3_W;
         trace_data  <= WD_W;
      end else begin
         trace_valid <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_wb_grf.sv
// Self-checking bench for wb_grf: directed vector table, corner sequences and
// randomized traffic against an array-based reference model.
module tb_wb_grf;
   logic        clk = 1'b0;
   logic        reset;
   logic        regWrite_W;
   logic [4:0]  A3_W;
   logic [2:0]  write2reg_W;
   logic [3:0]  lsOp_W;
   logic [31:0] readData_W, aluResult_W, PC_W, cp0Out_W;
   logic [4:0]  A1_D, A2_D;
   logic [31:0] RD1_D, RD2_D, WD_W;
`ifdef GRF_TRACE_EN
   logic        trace_valid;
   logic [31:0] trace_pc;
   logic [4:0]  trace_reg;
   logic [31:0] trace_data;
`endif

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] model [32];

   always #5 clk = ~clk;

   wb_grf dut (
      .clk(clk), .reset(reset), .regWrite_W(regWrite_W), .A3_W(A3_W),
      .write2reg_W(write2reg_W), .lsOp_W(lsOp_W), .readData_W(readData_W),
      .aluResult_W(aluResult_W), .PC_W(PC_W), .cp0Out_W(cp0Out_W),
      .A1_D(A1_D), .A2_D(A2_D), .RD1_D(RD1_D), .RD2_D(RD2_D), .WD_W(WD_W)
`ifdef GRF_TRACE_EN
     ,.trace_valid(trace_valid), .trace_pc(trace_pc), .trace_reg(trace_reg),
      .trace_data(trace_data)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_ext(input logic [3:0] ls, input logic [1:0] off,
                                           input logic [31:0] w);
      logic [7:0]         b;
      logic [15:0]        h;
      logic signed [7:0]  sb;
      logic signed [15:0] sh;
      b  = 8'(w >> (8 * off));
      h  = 16'(w >> (16 * off[1]));
      sb = b;
      sh = h;
      case (ls)
         4'd1:    return 32'(sh);
         4'd2:    return {16'h0, h};
         4'd3:    return 32'(sb);
         4'd4:    return {24'h0, b};
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] ref_wd();
      case (write2reg_W)
         3'd0:    return aluResult_W;
         3'd1:    return ref_ext(lsOp_W, aluResult_W[1:0], readData_W);
         3'd2:    return PC_W + 32'd8;
         3'd3:    return cp0Out_W;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] ref_rd(input logic [4:0] a);
      if (a == 5'd0) return 32'h0;
      if (regWrite_W && A3_W != 5'd0 && a == A3_W) return ref_wd();
      return model[a];
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
   endtask

   // Hold inputs across the rising edge, update the model, return on the falling edge.
   task automatic tick();
      logic        we_m;
      logic [31:0] wd_m;
      we_m = regWrite_W && A3_W != 5'd0;
      wd_m = ref_wd();
      @(posedge clk);
      if (reset && we_m) model[A3_W] = wd_m;
      @(negedge clk);
`ifdef GRF_TRACE_EN
      #1 check("trace_valid", {31'h0, trace_valid}, {31'h0, reset && we_m});
`endif
   endtask

   task automatic drive(input logic rw, input logic [4:0] a3, input logic [2:0] sel,
                        input logic [3:0] ls, input logic [31:0] rdata, input logic [31:0] alu,
                        input logic [31:0] pc, input logic [31:0] cp0,
                        input logic [4:0] a1, input logic [4:0] a2);
      regWrite_W = rw; A3_W = a3; write2reg_W = sel; lsOp_W = ls; readData_W = rdata;
      aluResult_W = alu; PC_W = pc; cp0Out_W = cp0; A1_D = a1; A2_D = a2;
      #1;
   endtask

   typedef struct {
      logic [2:0]  sel;
      logic [3:0]  ls;
      logic [31:0] rdata;
      logic [31:0] alu;
      logic [31:0] pc;
      logic [31:0] cp0;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs [15];

   initial begin
      vecs[0]  = '{3'd0, 4'd0, 32'h80FF7F01, 32'h12345678, 32'h0, 32'h0, 32'h12345678, "alu"};
      vecs[1]  = '{3'd1, 4'd3, 32'h80FF7F01, 32'h00000003, 32'h0, 32'h0, 32'hFFFFFF80, "lb_off3"};
      vecs[2]  = '{3'd1, 4'd4, 32'h80FF7F01, 32'h00000003, 32'h0, 32'h0, 32'h00000080, "lbu_off3"};
      vecs[3]  = '{3'd1, 4'd1, 32'h80FF7F01, 32'h00000002, 32'h0, 32'h0, 32'hFFFF80FF, "lh_off2"};
      vecs[4]  = '{3'd1, 4'd2, 32'h80FF7F01, 32'h00000000, 32'h0, 32'h0, 32'h00007F01, "lhu_off0"};
      vecs[5]  = '{3'd1, 4'd0, 32'h80FF7F01, 32'h00000002, 32'h0, 32'h0, 32'h80FF7F01, "lw"};
      vecs[6]  = '{3'd1, 4'd3, 32'h80FF7F01, 32'h00000000, 32'h0, 32'h0, 32'h00000001, "lb_off0"};
      vecs[7]  = '{3'd1, 4'd3, 32'h80FF7F01, 32'h00000001, 32'h0, 32'h0, 32'h0000007F, "lb_off1"};
      vecs[8]  = '{3'd1, 4'd4, 32'h80FF7F01, 32'h00000002, 32'h0, 32'h0, 32'h000000FF, "lbu_off2"};
      vecs[9]  = '{3'd1, 4'd1, 32'h80FF7F01, 32'h00000001, 32'h0, 32'h0, 32'h00007F01, "lh_off1"};
      vecs[10] = '{3'd1, 4'd7, 32'h80FF7F01, 32'h00000003, 32'h0, 32'h0, 32'h80FF7F01, "ls_other"};
      vecs[11] = '{3'd2, 4'd0, 32'h0, 32'h0, 32'h00003000, 32'h0, 32'h00003008, "pc8"};
      vecs[12] = '{3'd3, 4'd0, 32'h0, 32'h0, 32'h00003000, 32'h00000010, 32'h00000010, "cp0"};
      vecs[13] = '{3'd5, 4'd0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h00000000, "sel5"};
      vecs[14] = '{3'd1, 4'd2, 32'h80FF7F01, 32'h00000002, 32'h0, 32'h0, 32'h000080FF, "lhu_off2"};

      clear_model();
      reset = 1'b0;
      drive(1'b0, 5'd0, 3'd0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd31);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      check("reset_rd1", RD1_D, 32'h0);
      check("reset_rd2", RD2_D, 32'h0);

      // ALU write with same-cycle bypass, then held after commit
      drive(1'b1, 5'd8, 3'd0, 4'd0, 32'h0, 32'h12345678, 32'h0, 32'h0, 5'd8, 5'd8);
      check("alu_bypass_rd1", RD1_D, 32'h12345678);
      check("alu_bypass_rd2", RD2_D, 32'h12345678);
      tick();
      drive(1'b0, 5'd8, 3'd0, 4'd0, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 5'd8, 5'd9);
      check("alu_commit", RD1_D, 32'h12345678);
      check("bubble_no_bypass", RD2_D, 32'h0);
      tick();
      check("bubble_no_write", RD1_D, 32'h12345678);

      // $0 protection
      drive(1'b1, 5'd0, 3'd0, 4'd0, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd0, 5'd0);
      check("zero_wd_driven", WD_W, 32'hFFFFFFFF);
      check("zero_bypass_rd1", RD1_D, 32'h0);
      check("zero_bypass_rd2", RD2_D, 32'h0);
      tick();
      check("zero_after_edge", RD1_D, 32'h0);

      // Writeback select / load extension table, each committed to $9
      foreach (vecs[i]) begin
         drive(1'b1, 5'd9, vecs[i].sel, vecs[i].ls, vecs[i].rdata, vecs[i].alu,
               vecs[i].pc, vecs[i].cp0, 5'd9, 5'd9);
         check({vecs[i].name, "_wd"}, WD_W, vecs[i].exp);
         check({vecs[i].name, "_byp"}, RD1_D, vecs[i].exp);
         tick();
         drive(1'b0, 5'd9, 3'd0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd9, 5'd8);
         check({vecs[i].name, "_commit"}, RD2_D, 32'h12345678);
         check({vecs[i].name, "_stored"}, RD1_D, vecs[i].exp);
      end

      // PC+8 then CP0 into $31, back-to-back: last edge wins
      drive(1'b1, 5'd31, 3'd2, 4'd0, 32'h0, 32'h0, 32'h00003000, 32'h0, 5'd31, 5'd0);
      tick();
      check("pc8_commit", RD1_D, 32'h00003008);
      drive(1'b1, 5'd31, 3'd3, 4'd0, 32'h0, 32'h0, 32'h00003000, 32'h10, 5'd1, 5'd31);
      check("cp0_bypass_over_old", RD2_D, 32'h00000010);
      tick();
      drive(1'b0, 5'd0, 3'd0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd31, 5'd31);
      check("cp0_commit", RD1_D, 32'h00000010);

      // Async reset between edges, with a concurrent write dropped
      drive(1'b1, 5'd8, 3'd0, 4'd0, 32'h0, 32'h0000000A, 32'h0, 32'h0, 5'd8, 5'd8);
      tick();
      drive(1'b1, 5'd9, 3'd0, 4'd0, 32'h0, 32'h00000055, 32'h0, 32'h0, 5'd8, 5'd9);
      check("pre_reset_r8", RD1_D, 32'h0000000A);
      reset = 1'b0;
      clear_model();
      #1;
      check("async_reset_r8", RD1_D, 32'h0);
      check("reset_bypass_r9", RD2_D, 32'h00000055);
      tick();
      reset = 1'b1;
      drive(1'b0, 5'd0, 3'd0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd8, 5'd9);
      check("reset_dropped_r9", RD2_D, 32'h0);
      check("reset_cleared_r8", RD1_D, 32'h0);

      // Randomized traffic against the reference model
      for (int c = 0; c < 400; c++) begin
         logic [4:0] a3;
         a3 = 5'($urandom_range(0, 31));
         drive(1'($urandom_range(0, 3) != 0), a3, 3'($urandom_range(0, 7)),
               4'($urandom_range(0, 7)), $urandom, $urandom, $urandom, $urandom,
               ($urandom_range(0, 2) == 0) ? a3 : 5'($urandom_range(0, 31)),
               ($urandom_range(0, 2) == 0) ? a3 : 5'($urandom_range(0, 31)));
         check("rand_wd", WD_W, ref_wd());
         check("rand_rd1", RD1_D, ref_rd(A1_D));
         check("rand_rd2", RD2_D, ref_rd(A2_D));
         tick();
      end

      // Sweep every register through both read ports
      drive(1'b0, 5'd0, 3'd0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
      for (int r = 0; r < 32; r++) begin
         A1_D = 5'(r);
         A2_D = 5'(31 - r);
         #1;
         check("sweep_rd1", RD1_D, ref_rd(A1_D));
         check("sweep_rd2", RD2_D, ref_rd(A2_D));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
